// File: rtl/spi_mem_writer.sv
// Deserialises MSB-first SPI words from spi_bitstream and writes them to consecutive RAM
// addresses, optionally taking the start address from a leading header word.
module spi_mem_writer #(
  parameter int DW          = 16,
  parameter int AW          = 12,
  parameter bit ADDR_HEADER = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          si,
  input  logic          reset_flag,
  input  logic          valid_flag,
  output logic          so,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW:0]   words,
  output logic          overflow
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CTR_TOP  = CW'(DW - 1);
  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_FULL   = 2'd3
  } state_t;

  localparam state_t START_ST = ADDR_HEADER ? ST_HEADER : ST_DATA;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] bit_ctr_r;
  logic [DW-2:0] shreg_r;
  logic [DW-1:0] echo_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] word_s;
  logic          bit_acc_s, word_done_s;
  logic          do_write_s, do_ovf_s, load_addr_s;

  // Bit acceptance, word completion and next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    do_write_s  = 1'b0;
    do_ovf_s    = 1'b0;
    load_addr_s = 1'b0;
    bit_acc_s   = sel & valid_flag & ~reset_flag & (state_r != ST_IDLE);
    word_done_s = bit_acc_s & (bit_ctr_r == {CW{1'b0}});
    word_s      = {shreg_r, si};
    if (reset_flag) begin
      state_nxt_s = START_ST;
    end else if (word_done_s) begin
      case (state_r)
        ST_HEADER: begin
          load_addr_s = 1'b1;
          state_nxt_s = ST_DATA;
        end
        ST_DATA: begin
          do_write_s = 1'b1;
          // The last location was just written; further words only flag overflow.
          if (addr_r == ADDR_MAX) begin
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_FULL: begin
          do_ovf_s = 1'b1;
        end
        default: begin
          state_nxt_s = state_r;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shift register, bit counter, address/word counters and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_ctr_r <= CTR_TOP;
      shreg_r   <= {(DW-1){1'b0}};
      echo_r    <= {DW{1'b0}};
      addr_r    <= {AW{1'b0}};
      wr_en     <= 1'b0;
      wr_addr   <= {AW{1'b0}};
      wr_data   <= {DW{1'b0}};
      words     <= {(AW+1){1'b0}};
      overflow  <= 1'b0;
    end else begin
      wr_en <= do_write_s;
      if (reset_flag) begin
        bit_ctr_r <= CTR_TOP;
        addr_r    <= {AW{1'b0}};
        words     <= {(AW+1){1'b0}};
        echo_r    <= {DW{1'b0}};
        overflow  <= 1'b0;
      end else begin
        if (bit_acc_s) begin
          shreg_r   <= word_s[DW-2:0];
          bit_ctr_r <= (bit_ctr_r == {CW{1'b0}}) ? CTR_TOP : bit_ctr_r - {{(CW-1){1'b0}}, 1'b1};
        end
        if (load_addr_s) begin
          addr_r <= word_s[AW-1:0];
        end
        if (do_write_s) begin
          wr_data <= word_s;
          wr_addr <= addr_r;
          echo_r  <= word_s;
          words   <= words + {{AW{1'b0}}, 1'b1};
          // Address saturates at the top; FULL blocks any further writes.
          if (addr_r != ADDR_MAX) begin
            addr_r <= addr_r + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        if (do_ovf_s) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign so = echo_r[bit_ctr_r];

endmodule

// File: tb/tb_spi_mem_writer.sv
// Directed bench for spi_mem_writer: one instance without and one with the address header,
// both driven by the same SPI stimulus.
module tb_spi_mem_writer;

  logic clk = 1'b0;
  logic rst, sel, si, reset_flag, valid_flag;

  logic        so0, wr_en0, overflow0;
  logic [11:0] wr_addr0;
  logic [15:0] wr_data0;
  logic [12:0] words0;
  logic        so1, wr_en1, overflow1;
  logic [11:0] wr_addr1;
  logic [15:0] wr_data1;
  logic [12:0] words1;

  int n_tests = 0;
  int n_fail  = 0;
  int wcnt0 = 0, wcnt1 = 0, dbl_cnt = 0;
  logic prev_en0 = 1'b0, prev_en1 = 1'b0;
  int base0, base1;
  logic [15:0] so_bits;

  always #5 clk = ~clk;

  spi_mem_writer #(.DW(16), .AW(12), .ADDR_HEADER(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sel(sel), .si(si), .reset_flag(reset_flag), .valid_flag(valid_flag),
    .so(so0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .words(words0),
    .overflow(overflow0)
  );

  spi_mem_writer #(.DW(16), .AW(12), .ADDR_HEADER(1'b1)) dut1 (
    .clk(clk), .rst(rst), .sel(sel), .si(si), .reset_flag(reset_flag), .valid_flag(valid_flag),
    .so(so1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .words(words1),
    .overflow(overflow1)
  );

  // Count write strobes and catch back-to-back strobes.
  always @(negedge clk) begin
    if (wr_en0) wcnt0 <= wcnt0 + 1;
    if (wr_en1) wcnt1 <= wcnt1 + 1;
    if ((wr_en0 && prev_en0) || (wr_en1 && prev_en1)) dbl_cnt <= dbl_cnt + 1;
    prev_en0 <= wr_en0;
    prev_en1 <= wr_en1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic so_o);
    @(negedge clk);
    so_o       = so0;
    sel        = 1'b1;
    si         = b;
    valid_flag = 1'b1;
    @(negedge clk);
    valid_flag = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, output logic [15:0] so_w);
    logic s;
    for (int i = 15; i >= 0; i--) begin
      send_bit(w[i], s);
      so_w[i] = s;
    end
  endtask

  task automatic pulse_rf();
    @(negedge clk);
    reset_flag = 1'b1;
    @(negedge clk);
    reset_flag = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic s;
    rst = 1'b1; sel = 1'b0; si = 1'b0; reset_flag = 1'b0; valid_flag = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_wr_en",    {31'd0, wr_en0},    32'd0);
    check_val("rst_wr_addr",  {20'd0, wr_addr0},  32'd0);
    check_val("rst_wr_data",  {16'd0, wr_data1},  32'd0);
    check_val("rst_words",    {19'd0, words0},    32'd0);
    check_val("rst_overflow", {31'd0, overflow1}, 32'd0);
    check_val("rst_so",       {31'd0, so0},       32'd0);
    rst = 1'b0;

    // Plain word, no header.
    pulse_rf();
    base0 = wcnt0;
    send_word(16'hA5C3, so_bits);
    check_val("t1_wr_en",   {31'd0, wr_en0},   32'd1);
    check_val("t1_wr_addr", {20'd0, wr_addr0}, 32'd0);
    check_val("t1_wr_data", {16'd0, wr_data0}, 32'h0000A5C3);
    @(negedge clk);
    check_val("t1_wr_en_off", {31'd0, wr_en0}, 32'd0);
    check_val("t1_words",     {19'd0, words0}, 32'd1);
    check_val("t1_wr_data_hold", {16'd0, wr_data0}, 32'h0000A5C3);
    settle();
    check_val("t1_nwrites", wcnt0 - base0, 32'd1);

    // Header at 0xFFE, then three words into a two-location tail.
    pulse_rf();
    base1 = wcnt1;
    send_word(16'h0FFE, so_bits);
    check_val("t2_hdr_no_wr", {31'd0, wr_en1}, 32'd0);
    check_val("t2_hdr_words", {19'd0, words1}, 32'd0);
    send_word(16'h1111, so_bits);
    check_val("t2_w1_en",   {31'd0, wr_en1},   32'd1);
    check_val("t2_w1_addr", {20'd0, wr_addr1}, 32'h00000FFE);
    check_val("t2_w1_data", {16'd0, wr_data1}, 32'h00001111);
    send_word(16'h2222, so_bits);
    check_val("t2_w2_addr", {20'd0, wr_addr1}, 32'h00000FFF);
    check_val("t2_w2_data", {16'd0, wr_data1}, 32'h00002222);
    check_val("t2_w2_ovf",  {31'd0, overflow1}, 32'd0);
    send_word(16'h3333, so_bits);
    check_val("t2_w3_no_wr", {31'd0, wr_en1},    32'd0);
    check_val("t2_w3_ovf",   {31'd0, overflow1}, 32'd1);
    check_val("t2_words",    {19'd0, words1},    32'd2);
    check_val("t2_addr_hold", {20'd0, wr_addr1}, 32'h00000FFF);
    settle();
    check_val("t2_nwrites", wcnt1 - base1, 32'd2);

    // Echo of the previous word on so.
    pulse_rf();
    check_val("t3_ovf_cleared", {31'd0, overflow1}, 32'd0);
    send_word(16'hBEEF, so_bits);
    check_val("t3_so_first", {16'd0, so_bits}, 32'd0);
    send_word(16'h1234, so_bits);
    check_val("t3_so_echo", {16'd0, so_bits}, 32'h0000BEEF);
    check_val("t3_w2_addr", {20'd0, wr_addr0}, 32'd1);

    // Partial word discarded by reset_flag.
    pulse_rf();
    settle();
    base0 = wcnt0;
    for (int i = 0; i < 9; i++) send_bit(1'b1, s);
    pulse_rf();
    send_word(16'h00FF, so_bits);
    check_val("t4_addr", {20'd0, wr_addr0}, 32'd0);
    check_val("t4_data", {16'd0, wr_data0}, 32'h000000FF);
    settle();
    check_val("t4_nwrites", wcnt0 - base0, 32'd1);

    // reset_flag beats a same-cycle bit.
    @(negedge clk);
    reset_flag = 1'b1; sel = 1'b1; si = 1'b1; valid_flag = 1'b1;
    @(negedge clk);
    reset_flag = 1'b0; valid_flag = 1'b0;
    base0 = wcnt0;
    send_word(16'h8001, so_bits);
    check_val("t5_en",   {31'd0, wr_en0},   32'd1);
    check_val("t5_data", {16'd0, wr_data0}, 32'h00008001);
    check_val("t5_addr", {20'd0, wr_addr0}, 32'd0);
    settle();
    check_val("t5_nwrites", wcnt0 - base0, 32'd1);

    // Deselect mid-word ignores bits.
    pulse_rf();
    for (int i = 15; i >= 8; i--) send_bit(i[0] ? 1'b1 : 1'b0, s);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sel = 1'b0; si = 1'b1; valid_flag = 1'b1;
      @(negedge clk);
      valid_flag = 1'b0;
    end
    for (int i = 7; i >= 0; i--) send_bit(i[0] ? 1'b1 : 1'b0, s);
    check_val("t6_sel_data", {16'd0, wr_data0}, 32'h0000AAAA);
    check_val("t6_sel_en",   {31'd0, wr_en0},   32'd1);

    // rst in the completion cycle suppresses the write.
    settle();
    pulse_rf();
    base0 = wcnt0;
    for (int i = 0; i < 15; i++) send_bit(1'b1, s);
    @(negedge clk);
    sel = 1'b1; si = 1'b1; valid_flag = 1'b1; rst = 1'b1;
    @(negedge clk);
    valid_flag = 1'b0;
    check_val("t7_no_wr_en", {31'd0, wr_en0},   32'd0);
    check_val("t7_addr0",    {20'd0, wr_addr0}, 32'd0);
    check_val("t7_data0",    {16'd0, wr_data0}, 32'd0);
    check_val("t7_words0",   {19'd0, words0},   32'd0);
    check_val("t7_ovf0",     {31'd0, overflow0}, 32'd0);
    check_val("t7_so0",      {31'd0, so0},      32'd0);
    rst = 1'b0;
    settle();
    check_val("t7_nwrites", wcnt0 - base0, 32'd0);
    check_val("no_double_wr_en", dbl_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
